// File: rtl/apb_to_ahb_bridge.sv
// APB slave to AHB-Lite master bridge: each APB access becomes one single
// word AHB transfer. Misaligned APB addresses are rejected with PSLVERR and
// never reach the AHB side.
module apb_to_ahb_bridge #(
    parameter logic [15:0] HADDR_BASE = 16'h2000,
    parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
    input  logic        HCLK,
    input  logic        RESETn,
    // APB slave side
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic [15:0] PADDR,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    // AHB-Lite master side
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        HRESP
);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_DONE} state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        abort_q, abort_d;   // APB master walked away mid-transfer

    logic setup;
    logic aligned;

    assign setup   = PSEL & ~PENABLE;
    assign aligned = (PADDR[1:0] == 2'b00);

    assign HSIZE = HSIZE_WORD;
    assign HPROT = HPROT_VAL;

    // State register
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge HCLK or negedge RESETn) begin
        if (!RESETn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic: one AHB transfer per accepted setup phase
    always_comb begin
        // NOTE: assigning a default first keeps this purely combinational;
        // any path that leaves state_d unassigned would infer a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (setup) state_d = aligned ? ST_ADDR : ST_DONE;
            ST_ADDR: if (HREADY) state_d = ST_DATA;
            ST_DATA: if (HREADY) state_d = (abort_q | ~PSEL) ? ST_IDLE : ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Transfer context registers
    always_ff @(posedge HCLK or negedge RESETn) begin
        if (!RESETn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            abort_q <= abort_d;
        end
    end

    // Capture the APB request on setup, the AHB response on data-phase end
    always_comb begin
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        abort_d = abort_q;
        case (state_q)
            ST_IDLE: begin
                if (setup) begin
                    rdata_d = '0;
                    abort_d = 1'b0;
                    if (aligned) begin
                        addr_d  = PADDR;
                        write_d = PWRITE;
                        wdata_d = PWDATA;
                        err_d   = 1'b0;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            ST_ADDR: abort_d = abort_q | ~PSEL;
            ST_DATA: begin
                abort_d = abort_q | ~PSEL;
                // An HRESP=1 cycle with HREADY=0 is just the first half of
                // the two-cycle ERROR response; only the final cycle counts.
                if (HREADY) begin
                    err_d   = HRESP;
                    rdata_d = (!write_q && !HRESP) ? HRDATA : '0;
                end
            end
            default: ;
        endcase
    end

    // Bus outputs decoded from state so reset clears them asynchronously
    always_comb begin
        HTRANS  = HTRANS_IDLE;
        HADDR   = '0;
        HWRITE  = 1'b0;
        HWDATA  = '0;
        PREADY  = 1'b0;
        PRDATA  = '0;
        PSLVERR = 1'b0;
        case (state_q)
            ST_ADDR: begin
                HTRANS = HTRANS_NONSEQ;
                HADDR  = {HADDR_BASE, addr_q};
                HWRITE = write_q;
            end
            ST_DATA: HWDATA = wdata_q;
            ST_DONE: begin
                PREADY  = 1'b1;
                PRDATA  = rdata_q;
                PSLVERR = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_apb_to_ahb_bridge.sv
// Self-checking bench for apb_to_ahb_bridge. Each APB access is described
// as a transaction (address, direction, AHB wait counts, error, PSEL drop);
// the expected per-cycle bus picture is derived from the transaction timeline
// (latency = 3 + AHB waits) and compared against the DUT on every falling edge.
module tb_apb_to_ahb_bridge;

    localparam logic [15:0] BASE = 16'h2000;
    localparam logic [3:0]  PROT = 4'b0011;

    logic        hclk = 1'b0;
    logic        resetn;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0]  htrans;
    logic        hwrite, hready, hresp;
    logic [2:0]  hsize;
    logic [3:0]  hprot;

    apb_to_ahb_bridge #(.HADDR_BASE(BASE), .HPROT_VAL(PROT)) dut (
        .HCLK(hclk), .RESETn(resetn),
        .PSEL(psel), .PENABLE(penable), .PADDR(paddr), .PWRITE(pwrite),
        .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
        .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
        .HPROT(hprot), .HWDATA(hwdata), .HREADY(hready), .HRDATA(hrdata),
        .HRESP(hresp)
    );

    always #5 hclk = ~hclk;

    int n_checks = 0;
    int n_err    = 0;

    // Expected picture of the current cycle
    logic        chk_en = 1'b0;
    logic        exp_nonseq, exp_hwrite, exp_chk_hwdata, exp_reset;
    logic [31:0] exp_haddr, exp_hwdata, exp_prdata;
    logic        exp_pready, exp_pslverr;

    // Observations recorded for the literal checks
    int          cur_c = 0;
    int          pready_at = -1;
    logic [31:0] pready_data = '0;
    logic        pready_err = 1'b0;
    int          nonseq_at = -1;
    logic [31:0] nonseq_addr = '0;
    int          nonseq_cnt = 0;
    int          pready_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle_exp();
        exp_nonseq     = 1'b0;
        exp_hwrite     = 1'b0;
        exp_chk_hwdata = 1'b0;
        exp_reset      = 1'b0;
        exp_haddr      = '0;
        exp_hwdata     = '0;
        exp_pready     = 1'b0;
        exp_prdata     = '0;
        exp_pslverr    = 1'b0;
    endtask

    // Single compare process: checks the DUT against the expected picture
    always @(negedge hclk) begin
        if (chk_en) begin
            check("htrans",  32'(htrans),  exp_nonseq ? 32'h2 : 32'h0);
            check("pready",  32'(pready),  32'(exp_pready));
            check("prdata",  prdata,       exp_prdata);
            check("pslverr", 32'(pslverr), 32'(exp_pslverr));
            check("hsize",   32'(hsize),   32'h2);
            check("hprot",   32'(hprot),   32'(PROT));
            if (exp_nonseq) begin
                check("haddr",  haddr,        exp_haddr);
                check("hwrite", 32'(hwrite),  32'(exp_hwrite));
            end
            if (exp_chk_hwdata) check("hwdata", hwdata, exp_hwdata);
            if (exp_reset) begin
                check("rst_haddr",  haddr,       32'h0);
                check("rst_hwrite", 32'(hwrite), 32'h0);
                check("rst_hwdata", hwdata,      32'h0);
            end
            if (pready) begin
                pready_at   = cur_c;
                pready_data = prdata;
                pready_err  = pslverr;
                pready_cnt++;
            end
            if (htrans == 2'b10) begin
                nonseq_cnt++;
                if (nonseq_at < 0) begin
                    nonseq_at   = cur_c;
                    nonseq_addr = haddr;
                end
            end
        end
    end

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    // One APB access. aw/dw: AHB wait cycles in address/data phase; er: slave
    // answers with the two-cycle ERROR response; drop: cycle at which PSEL
    // falls (-1 = never); rst_c: cycle at which reset is pulsed (-1 = never).
    task automatic xfer(input logic [15:0] addr, input logic wr, input logic [31:0] wd,
                        input logic [31:0] rd, input int aw, input int dw, input logic er,
                        input int drop, input int rst_c, input int gap);
        logic mis;
        int   a_end, d_beg, d_end, done_c;
        mis    = (addr[1:0] != 2'b00);
        a_end  = 1 + aw;
        d_beg  = 2 + aw;
        d_end  = 2 + aw + dw;
        done_c = mis ? 1 : 3 + aw + dw;
        pready_at = -1;
        nonseq_at = -1;
        for (int c = 0; c <= done_c; c++) begin
            cur_c   = c;
            psel    = (drop < 0) || (c < drop);
            penable = (c >= 1) && psel;
            paddr   = addr;
            pwrite  = wr;
            pwdata  = wd;
            hready  = 1'b1;
            hresp   = 1'b0;
            hrdata  = $urandom;
            if (!mis) begin
                if (c >= 1 && c < a_end) hready = 1'b0;
                if (c >= d_beg && c < d_end) hready = 1'b0;
                if (er && (c == d_end || c == d_end - 1)) hresp = 1'b1;
                if (c == d_end) hrdata = rd;
            end
            set_idle_exp();
            if (!mis && c >= 1 && c <= a_end) begin
                exp_nonseq = 1'b1;
                exp_haddr  = {BASE, addr};
                exp_hwrite = wr;
            end
            if (!mis && wr && c >= d_beg && c <= d_end) begin
                exp_chk_hwdata = 1'b1;
                exp_hwdata     = wd;
            end
            if (c == done_c && drop < 0) begin
                exp_pready  = 1'b1;
                exp_pslverr = mis | er;
                exp_prdata  = (mis | wr | er) ? 32'h0 : rd;
            end
            if (c == rst_c) begin
                set_idle_exp();
                exp_reset = 1'b1;
                resetn = 1'b0;
                #1;
                check("rst_now_htrans", 32'(htrans), 32'h0);
                check("rst_now_pready", 32'(pready), 32'h0);
                check("rst_now_hwdata", hwdata,      32'h0);
                step();
                resetn = 1'b1;
                return;
            end
            step();
        end
        for (int g = 0; g < gap; g++) begin
            psel    = 1'b0;
            penable = 1'b0;
            hready  = 1'b1;
            hresp   = 1'b0;
            set_idle_exp();
            step();
        end
    endtask

    initial begin
        logic [15:0] ra;
        logic        rw, re;
        int          raw, rdw, rdr, ns0, pr0;

        resetn = 1'b0;
        psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0; pwdata = '0;
        hready = 1'b1; hrdata = '0; hresp = 1'b0;
        set_idle_exp();
        exp_reset = 1'b1;
        chk_en = 1'b1;
        repeat (3) step();
        resetn = 1'b1;

        // Zero-wait read: NONSEQ in cycle 1, PREADY in cycle 3
        xfer(16'h0010, 1'b0, 32'h0, 32'hCAFEBABE, 0, 0, 1'b0, -1, -1, 1);
        check("r041_nonseq_cycle", 32'(nonseq_at), 32'd1);
        check("r041_haddr",        nonseq_addr,    32'h20000010);
        check("r041_pready_cycle", 32'(pready_at), 32'd3);
        check("r041_prdata",       pready_data,    32'hCAFEBABE);
        check("r041_pslverr",      32'(pready_err), 32'h0);

        // Write with two data-phase waits: PREADY in cycle 5
        xfer(16'h0004, 1'b1, 32'h12345678, 32'h0, 0, 2, 1'b0, -1, -1, 1);
        check("r042_pready_cycle", 32'(pready_at), 32'd5);
        check("r042_pslverr",      32'(pready_err), 32'h0);

        // Two-cycle ERROR response on a read
        xfer(16'h0020, 1'b0, 32'h0, 32'hDEADBEEF, 0, 1, 1'b1, -1, -1, 1);
        check("r043_pslverr", 32'(pready_err), 32'h1);
        check("r043_prdata",  pready_data,     32'h0);

        // Misaligned access: no AHB transfer, error in cycle 1
        xfer(16'h0006, 1'b0, 32'h0, 32'h0, 0, 0, 1'b0, -1, -1, 1);
        check("r044_pready_cycle", 32'(pready_at), 32'd1);
        check("r044_pslverr",      32'(pready_err), 32'h1);
        check("r044_no_nonseq",    32'(nonseq_at),  32'hFFFFFFFF);

        // Access phase without a setup phase is ignored
        pr0 = pready_cnt;
        ns0 = nonseq_cnt;
        psel = 1'b1; penable = 1'b1; paddr = 16'h0040;
        set_idle_exp();
        step();
        psel = 1'b0; penable = 1'b0;
        repeat (2) step();
        check("r036_no_pready", 32'(pready_cnt - pr0), 32'd0);
        check("r036_no_nonseq", 32'(nonseq_cnt - ns0), 32'd0);

        // Reset pulsed during the data phase of a write, then a clean read
        xfer(16'h0008, 1'b1, 32'hA5A5A5A5, 32'h0, 0, 2, 1'b0, -1, 3, 0);
        xfer(16'h000C, 1'b0, 32'h0, 32'h0BADF00D, 0, 0, 1'b0, -1, -1, 1);
        check("r045_pready_cycle", 32'(pready_at), 32'd3);
        check("r045_prdata",       pready_data,    32'h0BADF00D);

        // Back-to-back reads
        ns0 = nonseq_cnt;
        pr0 = pready_cnt;
        xfer(16'h0000, 1'b0, 32'h0, 32'h11112222, 0, 0, 1'b0, -1, -1, 0);
        xfer(16'h0004, 1'b0, 32'h0, 32'h33334444, 0, 0, 1'b0, -1, -1, 1);
        check("r046_nonseq_count", 32'(nonseq_cnt - ns0), 32'd2);
        check("r046_pready_count", 32'(pready_cnt - pr0), 32'd2);

        // PSEL dropped mid-transfer: transfer completes, no PREADY
        pr0 = pready_cnt;
        xfer(16'h0030, 1'b0, 32'h0, 32'h55667788, 1, 1, 1'b0, 2, -1, 1);
        check("r035_no_pready", 32'(pready_cnt - pr0), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            ra = 16'($urandom) & 16'hFFFC;
            if ($urandom_range(5) == 0) ra[1:0] = 2'($urandom_range(3, 1));
            rw  = 1'($urandom_range(1));
            raw = int'($urandom_range(2));
            rdw = int'($urandom_range(3));
            re  = ($urandom_range(3) == 0);
            if (re && rdw == 0) rdw = 1;
            rdr = -1;
            if (ra[1:0] == 2'b00 && $urandom_range(7) == 0)
                rdr = int'($urandom_range(2 + raw + rdw, 1));
            xfer(ra, rw, $urandom, $urandom, raw, rdw, re, rdr, -1, int'($urandom_range(2)));
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
